// File: rtl/latency_credit_ctrl.sv
// Credit-based valid/ready wrapper around an external fixed-latency, enable-less delay line.
// Returning beats land in an FWFT FIFO; credit is granted only while in-flight + buffered beats fit in the FIFO.
module latency_credit_ctrl #(
  parameter int DWIDTH     = 8,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 6,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic [DWIDTH-1:0] pipe_din,
  input  logic [DWIDTH-1:0] pipe_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow
);

  localparam int                 PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR_C = PTR_W'(FIFO_DEPTH - 1);

  logic [CNT_W-1:0]  occ_r;
  logic [CNT_W-1:0]  occ_nxt_s;
  logic [CNT_W-1:0]  fifo_cnt_r;
  logic [CNT_W-1:0]  fifo_cnt_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LATENCY-1:0] trk_r;
  logic [DWIDTH-1:0] mem_r [FIFO_DEPTH];
  logic              overflow_r;
  logic              accept_s;
  logic              pop_s;
  logic              arrive_s;
  logic              fifo_full_s;
  logic              wr_en_s;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR_C) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Credit depends on registered occupancy only; a pop frees credit one cycle later.
  assign s_ready     = ~rst & (occ_r < DEPTH_C);
  assign accept_s    = s_valid & s_ready;
  assign pipe_din    = s_data;
  assign m_valid     = (fifo_cnt_r != {CNT_W{1'b0}});
  assign m_data      = mem_r[rd_ptr_r];
  assign pop_s       = m_valid & m_ready;
  assign arrive_s    = trk_r[LATENCY-1];
  assign fifo_full_s = (fifo_cnt_r == DEPTH_C);
  assign wr_en_s     = arrive_s & (~fifo_full_s | pop_s);
  assign occupancy   = occ_r;
  assign overflow    = overflow_r;

  // Next-value logic for the occupancy and FIFO counters.
  always_comb begin
    occ_nxt_s      = occ_r;
    fifo_cnt_nxt_s = fifo_cnt_r;
    case ({accept_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + CNT_W'(1);
      2'b01:   occ_nxt_s = occ_r - CNT_W'(1);
      default: occ_nxt_s = occ_r;
    endcase
    case ({wr_en_s, pop_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + CNT_W'(1);
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - CNT_W'(1);
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase
  end

  // Valid tracker mirrors the delay line so we know when pipe_dout carries a real beat.
  generate
    if (LATENCY == 1) begin : g_trk_one
      // Single-stage tracker.
      always_ff @(posedge clk) begin
        if (rst) begin
          trk_r <= 1'b0;
        end else begin
          trk_r <= accept_s;
        end
      end
    end else begin : g_trk_multi
      // Multi-stage tracker shifting every cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          trk_r <= {LATENCY{1'b0}};
        end else begin
          trk_r <= {trk_r[LATENCY-2:0], accept_s};
        end
      end
    end
  endgenerate

  // Counters, pointers and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r      <= {CNT_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      occ_r      <= occ_nxt_s;
      fifo_cnt_r <= fifo_cnt_nxt_s;
      if (wr_en_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      if (arrive_s & fifo_full_s & ~pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s & ~rst) begin
      mem_r[wr_ptr_r] <= pipe_dout;
    end
  end

endmodule

// File: tb/tb_latency_credit_ctrl.sv
// Scoreboard bench for latency_credit_ctrl with a behavioural 4-deep delay line.
// Stimulus pushes accepted beats into a queue; a monitor pops and compares on every output handshake.
module tb_latency_credit_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic [7:0] pipe_din;
  logic [7:0] pipe_dout;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [2:0] occupancy;
  logic       overflow;

  logic [7:0] dl [4];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  latency_credit_ctrl #(.DWIDTH(8), .LATENCY(4), .FIFO_DEPTH(6)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pipe_din(pipe_din), .pipe_dout(pipe_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // External free-running delay line, depth 4.
  always @(posedge clk) begin
    dl[0] <= pipe_din;
    dl[1] <= dl[0];
    dl[2] <= dl[1];
    dl[3] <= dl[2];
  end
  assign pipe_dout = dl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, record the beat if it will be accepted at the next posedge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic mr);
    @(negedge clk);
    rst = r;
    s_valid = v;
    s_data = d;
    m_ready = mr;
    if (r) exp_q.delete();
    #2;
    if (s_valid && s_ready) exp_q.push_back(s_data);
  endtask

  // Monitor: pending count tracking, overflow, and in-order data on each pop.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("occupancy_vs_pending", {29'd0, occupancy}, exp_q.size());
      chk("overflow_clear", {31'd0, overflow}, 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none at %0t", m_data, $time);
        end else begin
          chk("m_data_order", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    int acc;
    // Reset
    repeat (3) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("s_ready_in_reset", {31'd0, s_ready}, 32'd0);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_occupancy", {29'd0, occupancy}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_s_ready", {31'd0, s_ready}, 32'd1);

    // Streaming: first m_valid 5 cycles after first accept, no gaps
    for (int k = 0; k < 26; k++) begin
      cyc(1'b0, (k < 20), k[7:0], 1'b1);
      if (k < 20) chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
      chk("stream_m_valid", {31'd0, m_valid}, (k >= 5 && k <= 24) ? 32'd1 : 32'd0);
    end

    // Backpressure fill: exactly 6 accepted
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1, 8'hA0 + k[7:0], 1'b0);
      chk("fill_s_ready", {31'd0, s_ready}, (k < 6) ? 32'd1 : 32'd0);
      chk("fill_occupancy", {29'd0, occupancy}, (k < 6) ? k : 32'd6);
      if (s_ready) acc++;
    end
    chk("fill_accept_count", acc, 32'd6);
    chk("fill_m_valid", {31'd0, m_valid}, 32'd1);
    chk("fill_head", {24'd0, m_data}, 32'hA0);

    // Drain one beat: credit returns next cycle
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_same_cycle_s_ready", {31'd0, s_ready}, 32'd0);
    chk("drain_occ_before", {29'd0, occupancy}, 32'd6);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("drain_occ_after", {29'd0, occupancy}, 32'd5);
    chk("drain_s_ready_next", {31'd0, s_ready}, 32'd1);
    chk("drain_new_head", {24'd0, m_data}, 32'hA1);

    // Simultaneous accept/pop and arrive/pop across pointer wraps
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 8'hC0 + k[7:0], 1'b1);
      chk("simul_occupancy", {29'd0, occupancy}, 32'd5);
      chk("simul_m_valid", {31'd0, m_valid}, 32'd1);
    end
    repeat (12) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("simul_drained_occ", {29'd0, occupancy}, 32'd0);
    chk("simul_drained_q", exp_q.size(), 32'd0);

    // Reset mid-flight: 2 buffered, 3 in flight
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 8'h10 + k[7:0], 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("pre_reset_occ", {29'd0, occupancy}, 32'd5);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_reset_m_valid", {31'd0, m_valid}, 32'd0);
    chk("post_reset_occ", {29'd0, occupancy}, 32'd0);
    chk("post_reset_s_ready", {31'd0, s_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("stale_beat_suppressed", {31'd0, m_valid}, 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, (k == 0), 8'h5A, 1'b1);
      chk("lone_beat_m_valid", {31'd0, m_valid}, (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) chk("lone_beat_data", {24'd0, m_data}, 32'h5A);
    end
    chk("lone_beat_q", exp_q.size(), 32'd0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (20) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("random_drained_q", exp_q.size(), 32'd0);
    chk("random_drained_occ", {29'd0, occupancy}, 32'd0);
    chk("random_overflow", {31'd0, overflow}, 32'd0);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
